// File: rtl/adc_oversample_sequencer.sv
// Settle / trigger / accumulate sequencer for the shared pixel ADC.
// Each accepted request returns one truncated average of 2^k samples, or an error strobe on timeout.
module adc_oversample_sequencer #(
  parameter int unsigned NB_DATA      = 12,
  parameter int unsigned MAX_AVG_LOG2 = 3,
  parameter int unsigned NB_SETTLE    = 8,
  parameter int unsigned NB_TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic                  i_abort,
  input  logic [2:0]            i_avg_log2,
  input  logic [NB_SETTLE-1:0]  i_settle,
  input  logic [NB_TIMEOUT-1:0] i_timeout,
  input  logic [NB_DATA-1:0]    i_adc_val,
  input  logic                  i_adc_done,
  output logic                  o_adc_trigger,
  output logic                  o_busy,
  output logic [NB_DATA-1:0]    o_val,
  output logic                  o_valid,
  output logic                  o_err
);

  localparam int unsigned NB_ACC = NB_DATA + MAX_AVG_LOG2;
  localparam int unsigned NB_SMP = MAX_AVG_LOG2 + 1;
  localparam int unsigned NB_CYC = (NB_SETTLE > NB_TIMEOUT) ? NB_SETTLE : NB_TIMEOUT;
  localparam int unsigned NB_K   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    TRIG   = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                 state_q, state_n;
  logic [NB_CYC-1:0]      cyc_q, cyc_n;
  logic [NB_ACC-1:0]      acc_q, acc_n;
  logic [NB_SMP-1:0]      smp_q, smp_n;
  logic [NB_SETTLE-1:0]   settle_q, settle_n;
  logic [NB_TIMEOUT-1:0]  timeout_q, timeout_n;
  logic [NB_K-1:0]        k_q, k_n;
  logic [NB_DATA-1:0]     val_q, val_n;
  logic                   trig_q, busy_q, valid_q, err_q;
  logic                   err_n;

  // Next-state, datapath and output decode; outputs are registered from state_n.
  always_comb begin
    state_n   = state_q;
    cyc_n     = cyc_q;
    acc_n     = acc_q;
    smp_n     = smp_q;
    settle_n  = settle_q;
    timeout_n = timeout_q;
    k_n       = k_q;
    val_n     = val_q;
    err_n     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req && !i_abort) begin
          settle_n  = i_settle;
          timeout_n = i_timeout;
          k_n       = (i_avg_log2 > NB_K'(MAX_AVG_LOG2)) ? NB_K'(MAX_AVG_LOG2) : i_avg_log2;
          acc_n     = '0;
          smp_n     = '0;
          cyc_n     = '0;
          state_n   = (i_settle != '0) ? SETTLE : TRIG;
        end
      end
      SETTLE: begin
        if (cyc_q == NB_CYC'(settle_q) - NB_CYC'(1)) begin
          cyc_n   = '0;
          state_n = TRIG;
        end else begin
          cyc_n = cyc_q + NB_CYC'(1);
        end
      end
      TRIG: begin
        cyc_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // A done arriving in the expiry cycle still counts as a sample.
        if (i_adc_done) begin
          acc_n   = acc_q + NB_ACC'(i_adc_val);
          smp_n   = smp_q + NB_SMP'(1);
          state_n = (smp_n == (NB_SMP'(1) << k_q)) ? DONE : TRIG;
        end else if ((timeout_q != '0) &&
                     (cyc_q == NB_CYC'(timeout_q) - NB_CYC'(1))) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          cyc_n = cyc_q + NB_CYC'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if ((state_q != IDLE) && i_abort) begin
      state_n = IDLE;
      acc_n   = '0;
      smp_n   = '0;
      cyc_n   = '0;
      err_n   = 1'b0;
    end

    if (state_n == DONE) begin
      val_n = err_n ? '0 : NB_DATA'(acc_n >> k_q);
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      acc_q     <= '0;
      smp_q     <= '0;
      settle_q  <= '0;
      timeout_q <= '0;
      k_q       <= '0;
      val_q     <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cyc_q     <= cyc_n;
      acc_q     <= acc_n;
      smp_q     <= smp_n;
      settle_q  <= settle_n;
      timeout_q <= timeout_n;
      k_q       <= k_n;
      val_q     <= val_n;
      trig_q    <= (state_n == TRIG);
      busy_q    <= (state_n != IDLE);
      valid_q   <= (state_n == DONE);
      err_q     <= (state_n == DONE) && err_n;
    end
  end

  assign o_adc_trigger = trig_q;
  assign o_busy        = busy_q;
  assign o_val         = val_q;
  assign o_valid       = valid_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_adc_oversample_sequencer.sv
// Directed bench for adc_oversample_sequencer: cycle-by-cycle output checks against
// hand-derived timing for conversion, averaging, clamping, timeout, abort and reset.
module tb_adc_oversample_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req = 1'b0;
  logic        i_abort = 1'b0;
  logic [2:0]  i_avg_log2 = 3'd0;
  logic [7:0]  i_settle = 8'd0;
  logic [15:0] i_timeout = 16'd0;
  logic [11:0] i_adc_val = 12'h000;
  logic        i_adc_done = 1'b0;
  logic        o_adc_trigger;
  logic        o_busy;
  logic [11:0] o_val;
  logic        o_valid;
  logic        o_err;

  int n_cmp = 0;
  int n_err = 0;
  int trig_cnt;
  logic [31:0] obs_v;

  adc_oversample_sequencer #(
    .NB_DATA(12), .MAX_AVG_LOG2(3), .NB_SETTLE(8), .NB_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_abort(i_abort),
    .i_avg_log2(i_avg_log2), .i_settle(i_settle), .i_timeout(i_timeout),
    .i_adc_val(i_adc_val), .i_adc_done(i_adc_done),
    .o_adc_trigger(o_adc_trigger), .o_busy(o_busy), .o_val(o_val),
    .o_valid(o_valid), .o_err(o_err)
  );

  always #5 clk = ~clk;

  assign obs_v = {16'h0, o_adc_trigger, o_busy, o_valid, o_err, o_val};

  function automatic logic [31:0] ev(input bit t, input bit b, input bit v,
                                     input bit e, input logic [11:0] val);
    return {16'h0, t, b, v, e, val};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs must clear asynchronously.
    #2 rst_n = 1'b0;
    #1 chk("reset_async", obs_v, ev(0, 0, 0, 0, 12'h000));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_idle", obs_v, ev(0, 0, 0, 0, 12'h000));

    // Basic conversion: S=0, k=0, done high, val 0x123.
    i_adc_done = 1'b1; i_adc_val = 12'h123;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    chk("basic_c1", obs_v, ev(1, 1, 0, 0, 12'h000));
    tick(); chk("basic_c2", obs_v, ev(0, 1, 0, 0, 12'h000));
    tick(); chk("basic_c3", obs_v, ev(0, 1, 1, 0, 12'h123));
    tick(); chk("basic_c4", obs_v, ev(0, 0, 0, 0, 12'h123));

    // Averaging with settle: S=3, k=2; samples captured in WAIT cycles 5,7,9,11.
    i_settle = 8'd3; i_avg_log2 = 3'd2; i_adc_val = 12'hABC;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      chk($sformatf("avg_c%0d", n), obs_v,
          ev((n >= 4) && (n <= 10) && (n % 2 == 0), n <= 12, n == 12, 0,
             (n < 12) ? 12'h123 : 12'h012));
      case (n)
        5:       i_adc_val = 12'h010;
        7:       i_adc_val = 12'h011;
        9:       i_adc_val = 12'h012;
        11:      i_adc_val = 12'h015;
        default: i_adc_val = 12'hABC;
      endcase
      if (n < 13) tick();
    end

    // Clamp k=7 -> 8 samples of full scale; config changes mid-run must not matter.
    i_settle = 8'd0; i_avg_log2 = 3'd7; i_adc_val = 12'hFFF;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    trig_cnt = 0;
    for (int n = 1; n <= 18; n++) begin
      if (o_adc_trigger) trig_cnt++;
      chk($sformatf("clamp_c%0d", n), obs_v,
          ev((n <= 15) && (n % 2 == 1), n <= 17, n == 17, 0,
             (n < 17) ? 12'h012 : 12'hFFF));
      if (n == 2) begin
        i_settle = 8'd5; i_avg_log2 = 3'd0; i_timeout = 16'd1;
      end
      if (n < 18) tick();
    end
    chk("clamp_trig_count", 32'(trig_cnt), 32'd8);

    // Timeout: T=5, done low -> WAIT cycles 2..6, error strobe in cycle 7.
    i_settle = 8'd0; i_avg_log2 = 3'd0; i_timeout = 16'd5; i_adc_done = 1'b0;
    i_adc_val = 12'h777;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      chk($sformatf("tmo_c%0d", n), obs_v,
          ev(n == 1, n <= 7, n == 7, n == 7, (n < 7) ? 12'hFFF : 12'h000));
      if (n < 8) tick();
    end

    // Done arrives in the 5th WAIT cycle: sample accepted, no error.
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      chk($sformatf("edge_c%0d", n), obs_v,
          ev(n == 1, n <= 7, n == 7, 0, (n < 7) ? 12'h000 : 12'h2A5));
      if (n == 6) begin i_adc_done = 1'b1; i_adc_val = 12'h2A5; end
      if (n == 7) i_adc_done = 1'b0;
      if (n < 8) tick();
    end

    // Abort on the 2nd trigger of a k=2 request.
    i_timeout = 16'd0; i_avg_log2 = 3'd2; i_adc_done = 1'b1; i_adc_val = 12'h100;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      chk($sformatf("abort_c%0d", n), obs_v,
          ev((n == 1) || (n == 3), n <= 3, 0, 0, 12'h2A5));
      i_abort = (n == 3);
      if (n < 7) tick();
    end

    // Abort together with req in IDLE: request ignored.
    i_req = 1'b1; i_abort = 1'b1;
    tick();
    i_req = 1'b0; i_abort = 1'b0;
    chk("abort_req_idle", obs_v, ev(0, 0, 0, 0, 12'h2A5));

    // Follow-up k=0 request must not see the aborted accumulation.
    i_avg_log2 = 3'd0; i_adc_val = 12'h055;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("post_abort_c%0d", n), obs_v,
          ev(n == 1, n <= 3, n == 3, 0, (n < 3) ? 12'h2A5 : 12'h055));
      if (n < 4) tick();
    end

    // Reset pulsed in WAIT.
    i_avg_log2 = 3'd1; i_adc_done = 1'b0;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    chk("rst_mid_c1", obs_v, ev(1, 1, 0, 0, 12'h055));
    tick();
    chk("rst_mid_c2", obs_v, ev(0, 1, 0, 0, 12'h055));
    rst_n = 1'b0;
    #1 chk("rst_mid_async", obs_v, ev(0, 0, 0, 0, 12'h000));
    tick();
    chk("rst_mid_held", obs_v, ev(0, 0, 0, 0, 12'h000));
    rst_n = 1'b1;
    i_avg_log2 = 3'd0; i_adc_done = 1'b1; i_adc_val = 12'h321;
    tick();
    chk("rst_mid_idle", obs_v, ev(0, 0, 0, 0, 12'h000));
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("post_rst_c%0d", n), obs_v,
          ev(n == 1, n <= 3, n == 3, 0, (n < 3) ? 12'h000 : 12'h321));
      if (n < 4) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
